// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and defaults for the clk_div_ctrl divider.
//   state_e      FSM state encoding (IDLE, RUN, STOP)
//   CNT_W_DEF    default width of ratio and counter
//   DIV_RST_DEF  default active ratio after reset
package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: run request, ratio config handshake and divider outputs.
//   en         run request (level)
//   cfg_valid  ratio offered, cfg_div carries it; cfg_ready = can accept
//   cfg_err    one-cycle pulse when a zero ratio was accepted
//   tick       one-cycle enable at the last cycle of each period
//   div_out    divided square wave
//   busy       divider is running or finishing its last period
//   cur_div    active ratio
interface clk_div_ctrl_if #(parameter int CNT_W = 8);

  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             div_out;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, tick, div_out, busy, cur_div
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, tick, div_out, busy, cur_div
  );

endinterface

// File: rtl/div_period_cnt.sv
// div_period_cnt: period counter with terminal-count and half-period compares.
//   clk, rst    clock, async active-high reset
//   run         count this cycle (otherwise the counter is held at 0)
//   cur_div     ratio of the period in progress (drives the wrap compare)
//   nxt_div     ratio that will be active next cycle (drives the look-ahead compares)
//   wrap        counter is at cur_div-1 while running
//   tick_nxt    next count value is the last of its period
//   div_nxt     next count value lies in the high phase
module div_period_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] cur_div,
  input  logic [CNT_W-1:0] nxt_div,
  output logic             wrap,
  output logic             tick_nxt,
  output logic             div_nxt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;

  assign wrap = run && (cnt == cur_div - ONE);

  always_comb begin
    cnt_nxt = '0;
    if (run && !wrap) cnt_nxt = cnt + ONE;
  end

  // ceil(N/2) without widening: N>>1 plus the odd bit
  assign half     = (nxt_div >> 1) + {{(CNT_W-1){1'b0}}, nxt_div[0]};
  assign tick_nxt = (cnt_nxt == nxt_div - ONE);
  assign div_nxt  = (cnt_nxt < half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable glitch-free divider controller.
//   clk, rst  sole clock, async active-high reset
//   bus       clk_div_ctrl_if.slave (run request, ratio config, divider outputs)
// All outputs are flops loaded from next-cycle values; cfg_ready is !pend_vld.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] STOP = ST_STOP;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cur_div_q, pend, ratio_nxt;
  logic             pend_vld;
  logic             run, active_nxt, accept, cfg_zero, apply_pend;
  logic             wrap, tick_nxt, div_nxt;
  logic             tick_q, div_q, busy_q, err_q;

  assign run        = (state != IDLE);
  assign accept     = bus.cfg_valid && !pend_vld;
  assign cfg_zero   = (bus.cfg_div == '0);
  // A ratio accepted in the final STOP wrap lands in IDLE still pending; it is
  // applied there so the handshake never stalls.
  assign apply_pend = pend_vld && (!run || wrap);
  assign active_nxt = (state_nxt != IDLE);

  always_comb begin
    ratio_nxt = cur_div_q;
    if (apply_pend)                      ratio_nxt = pend;
    else if (!run && accept && !cfg_zero) ratio_nxt = bus.cfg_div;
  end

  // en has priority in STOP, so re-raising it even in the wrap cycle keeps running
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = RUN;
      RUN:     if (!bus.en) state_nxt = STOP;
      STOP:    if (bus.en) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  div_period_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cur_div  (cur_div_q),
    .nxt_div  (ratio_nxt),
    .wrap     (wrap),
    .tick_nxt (tick_nxt),
    .div_nxt  (div_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_div_q <= CNT_W'(DIV_RST);
      pend      <= '0;
      pend_vld  <= 1'b0;
      tick_q    <= 1'b0;
      div_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_div_q <= ratio_nxt;
      if (apply_pend) pend_vld <= 1'b0;
      if (run && accept && !cfg_zero) begin
        pend     <= bus.cfg_div;
        pend_vld <= 1'b1;
      end
      tick_q <= active_nxt && tick_nxt;
      div_q  <= active_nxt && div_nxt;
      busy_q <= active_nxt;
      err_q  <= accept && cfg_zero;
    end
  end

  assign bus.cfg_ready = !pend_vld;
  assign bus.cfg_err   = err_q;
  assign bus.tick      = tick_q;
  assign bus.div_out   = div_q;
  assign bus.busy      = busy_q;
  assign bus.cur_div   = cur_div_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable, glitch-free clock-divider controller. It replaces ripple-clocked flop chains with a single-clock counter that produces a one-cycle `tick` enable and a square-wave `div_out` at a runtime-selected ratio N. Ratio changes arrive over a valid/ready config port and take effect only at a period boundary. It sits between the configuration logic and every consumer of divided-rate enables, and it is the only block that sequences the divider.

## Interface
- `CNT_W`, default 8: width of the divide ratio and the counter.
- `DIV_RST`, default 4: active ratio loaded at reset.
- `clk` in 1: sole clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: run request, level-sensitive.
- `cfg_valid` in 1: a new ratio is offered.
- `cfg_div` in CNT_W: the offered ratio N.
- `cfg_ready` out 1: the block can accept a ratio this cycle.
- `cfg_err` out 1: one-cycle pulse when an accepted `cfg_div` is 0.
- `tick` out 1: one-cycle enable at the last cycle of each period.
- `div_out` out 1: divided square wave.
- `busy` out 1: high in RUN or STOP.
- `cur_div` out CNT_W: the active ratio.

## Operation
- Every output is driven directly from a flop; no combinational output paths except `cfg_ready`, which equals `!pend_vld`.
- Reset values: state=IDLE, cnt=0, `cur_div`=DIV_RST, pend=0, `pend_vld`=0, `tick`=0, `div_out`=0, `busy`=0, `cfg_err`=0.
- A config is accepted when `cfg_valid` and `cfg_ready` are both high at a clock edge.
  - `cfg_div`=0 is discarded, `cfg_err` pulses, and the state is unchanged.
  - In IDLE, an accepted nonzero ratio loads `cur_div` directly.
  - In RUN or STOP, it is stored in pend and `pend_vld` is set.
- States:
  - IDLE: counter held at 0; `tick`=0, `div_out`=0. If `en`=1, go to RUN with cnt=0.
  - RUN: cnt counts 0..N-1 and wraps. If `en`=0, go to STOP; the current period is not cut short.
  - STOP: counting continues. At wrap, go to IDLE. If `en` returns to 1 before wrap, go back to RUN with no phase disturbance.
- At every wrap (cnt==N-1 in RUN or STOP) with `pend_vld`=1: `cur_div`←pend, `pend_vld`←0, and the new period starts at cnt=0 with the new N.
- Waveform in RUN/STOP:
  - `tick`=1 exactly in cycles where cnt==N-1.
  - `div_out`=1 for cnt in [0, ceil(N/2)-1], 0 otherwise.
- N=1: `tick`=1 every cycle; `div_out` stays 1.
- Arithmetic is unsigned CNT_W. Comparisons are against `cur_div`-1, so N=2^CNT_W-1 is the maximum ratio, with no overflow.
- Simultaneous events:
  - Config accepted in the wrap cycle: stored in pend, applied at the following wrap.
  - `en` falls in the wrap cycle: go to STOP, and the next full period runs before IDLE.
  - Config offered while `pend_vld`=1: `cfg_ready`=0, so it is held off.
- `rst` asserted mid-period: all state returns to reset values immediately; a pending ratio is lost.

## Timing
- `en` sampled high in IDLE at edge k: from cycle k+1, `busy`=1, cnt=0, `div_out`=1; first `tick` in cycle k+N.
- `tick` period is exactly N cycles. `div_out` has a period of N with a high phase of ceil(N/2).
- Config accepted in RUN: `cfg_ready` goes low the next cycle and returns high the cycle after the applying wrap.
- `cfg_err` is high the cycle after the accepting edge, for one cycle.
- STOP→IDLE: `busy` falls the cycle after the final `tick`.

## Structure
- Package `clk_div_pkg`: state enum (IDLE, RUN, STOP), default constants for CNT_W and DIV_RST.
- Sub-module `div_period_cnt`: a counter with a terminal-count compare and half-period compare. It takes `cur_div` and a run/clear control, and outputs `wrap`, `tick_nxt`, `div_nxt`.
- The top level holds the FSM, the pend register, and the config handshake.

## Test plan
- Reset then `en`=1 with default N=4: `tick` every 4th cycle; `div_out` is 1,1,0,0 repeating; `cur_div`=4.
- IDLE, config N=5, then `en`=1: `div_out` is 1,1,1,0,0; `tick` every 5 cycles.
- RUN N=4, config N=6 accepted at cnt=1: the period finishes at 4 cycles, then 6-cycle periods follow; `cfg_ready` is low until that wrap.
- RUN N=3, `en` dropped at cnt=0: two more cycles, then `tick`, then `busy`=0. With `en` re-raised at cnt=1, the period is uninterrupted.
- Config `cfg_div`=0 in RUN: `cfg_err` pulses once, `cur_div` is unchanged. Config N=1: `tick` is constant 1 and `div_out` stays 1.
- `rst` pulsed mid-period with a pend pending: all outputs return to reset values asynchronously; `cur_div`=4 and `pend_vld`=0 afterwards.
